// File: rtl/sprite_renderer.sv
// sprite_renderer: turns sprite move pulses into a one-pixel-per-clock stream
// for a 160x120, 3-bit-colour VGA adapter. Each moved sprite has its last drawn
// footprint erased with the background colour, then its new footprint drawn.
// Optional build macro: SPRITE_RENDERER_CLEAR_EN -- when defined, load_level
// also starts a full-screen background clear (19200 pixels).
module sprite_renderer #(
    parameter logic [2:0] PLAYER_W      = 3'd3,
    parameter logic [2:0] PLAYER_COLOUR = 3'b010,
    parameter logic [2:0] BULLET_COLOUR = 3'b110,
    parameter logic [2:0] BG_COLOUR     = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_level,
    input  logic       player_move,
    input  logic [7:0] playerX,
    input  logic [6:0] playerY,
    input  logic       enemy_move,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic [2:0] enemy_width,
    input  logic [2:0] enemy_color,
    input  logic       bullet_move,
    input  logic [7:0] bulletX,
    input  logic [6:0] bulletY,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);
    localparam int         NSPR      = 3;
    localparam logic [1:0] ID_PLAYER = 2'd0;
    localparam logic [1:0] ID_ENEMY  = 2'd1;
    localparam logic [1:0] ID_BULLET = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_CLEAR} state_t;

    state_t     state_q;
    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] move_vec;
    logic [2:0] accept;

    // Sprite chosen in IDLE and its live inputs
    logic [1:0] sel_id;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_size;
    logic [2:0] sel_colour;

    // Snapshot of the sprite being serviced
    logic [1:0] snap_id_q;
    logic [7:0] snap_x_q;
    logic [6:0] snap_y_q;
    logic [2:0] snap_size_q;
    logic [2:0] snap_colour_q;

    // Last drawn footprint per sprite
    logic [7:0]      shadow_x_q    [NSPR];
    logic [6:0]      shadow_y_q    [NSPR];
    logic [2:0]      shadow_size_q [NSPR];
    logic [NSPR-1:0] shadow_valid_q;

    logic [2:0] dx_q;
    logic [2:0] dy_q;

    logic [7:0] x_q;
    logic [6:0] y_q;
    logic [2:0] colour_q;
    logic       plot_q;

`ifdef SPRITE_RENDERER_CLEAR_EN
    logic [7:0] cx_q;
    logic [6:0] cy_q;
`endif

    // Current scan geometry and pixel address
    logic [7:0] scan_base_x;
    logic [6:0] scan_base_y;
    logic [2:0] scan_size;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_in;
    logic       dx_last;
    logic       dy_last;

    assign move_vec = {bullet_move, enemy_move, player_move};

    // Fixed-priority selection of a pending sprite while idle
    always_comb begin
        accept = 3'b000;
        sel_id = ID_PLAYER;
        if (state_q == S_IDLE && !load_level) begin
            if (pend_q[0]) begin
                accept = 3'b001;
                sel_id = ID_PLAYER;
            end else if (pend_q[1]) begin
                accept = 3'b010;
                sel_id = ID_ENEMY;
            end else if (pend_q[2]) begin
                accept = 3'b100;
                sel_id = ID_BULLET;
            end
        end
        case (sel_id)
            ID_ENEMY: begin
                sel_x      = enemyX;
                sel_y      = enemyY;
                sel_size   = enemy_width;
                sel_colour = enemy_color;
            end
            ID_BULLET: begin
                sel_x      = bulletX;
                sel_y      = bulletY;
                sel_size   = 3'd1;
                sel_colour = BULLET_COLOUR;
            end
            default: begin
                sel_x      = playerX;
                sel_y      = playerY;
                sel_size   = PLAYER_W;
                sel_colour = PLAYER_COLOUR;
            end
        endcase
    end

    // Erase scans the old footprint, draw scans the snapshot; widened sums catch off-screen pixels
    always_comb begin
        if (state_q == S_ERASE) begin
            scan_base_x = shadow_x_q[snap_id_q];
            scan_base_y = shadow_y_q[snap_id_q];
            scan_size   = shadow_size_q[snap_id_q];
        end else begin
            scan_base_x = snap_x_q;
            scan_base_y = snap_y_q;
            scan_size   = snap_size_q;
        end
        pix_x   = {1'b0, scan_base_x} + {6'd0, dx_q};
        pix_y   = {1'b0, scan_base_y} + {5'd0, dy_q};
        pix_in  = (pix_x < 9'd160) && (pix_y < 8'd120);
        dx_last = (dx_q == scan_size - 3'd1);
        dy_last = (dy_q == scan_size - 3'd1);
    end

    // A new pulse wins over acceptance, so a re-move during service is queued again
    genvar gi;
    generate
        for (gi = 0; gi < NSPR; gi++) begin : g_pend
            assign pend_d[gi] = load_level ? 1'b0
                              : ((pend_q[gi] & ~accept[gi]) | move_vec[gi]);
        end
    endgenerate

    // Pending move flags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= 3'b000;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Main sequencer with registered pixel outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            x_q            <= 8'd0;
            y_q            <= 7'd0;
            colour_q       <= 3'd0;
            plot_q         <= 1'b0;
            dx_q           <= 3'd0;
            dy_q           <= 3'd0;
            snap_id_q      <= ID_PLAYER;
            snap_x_q       <= 8'd0;
            snap_y_q       <= 7'd0;
            snap_size_q    <= 3'd0;
            snap_colour_q  <= 3'd0;
            shadow_valid_q <= '0;
            for (int i = 0; i < NSPR; i++) begin
                shadow_x_q[i]    <= 8'd0;
                shadow_y_q[i]    <= 7'd0;
                shadow_size_q[i] <= 3'd0;
            end
`ifdef SPRITE_RENDERER_CLEAR_EN
            cx_q <= 8'd0;
            cy_q <= 7'd0;
`endif
        end else if (load_level) begin
            shadow_valid_q <= '0;
            plot_q         <= 1'b0;
            dx_q           <= 3'd0;
            dy_q           <= 3'd0;
`ifdef SPRITE_RENDERER_CLEAR_EN
            state_q <= S_CLEAR;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
`else
            state_q <= S_IDLE;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    if (accept != 3'b000) begin
                        snap_id_q     <= sel_id;
                        snap_x_q      <= sel_x;
                        snap_y_q      <= sel_y;
                        snap_size_q   <= sel_size;
                        snap_colour_q <= sel_colour;
                        dx_q          <= 3'd0;
                        dy_q          <= 3'd0;
                        if (shadow_valid_q[sel_id] && shadow_size_q[sel_id] != 3'd0) begin
                            state_q <= S_ERASE;
                        end else if (sel_size != 3'd0) begin
                            state_q <= S_DRAW;
                        end else begin
                            // Nothing to erase or draw: just forget the sprite
                            shadow_valid_q[sel_id] <= 1'b0;
                        end
                    end
                end
                S_ERASE: begin
                    x_q      <= pix_x[7:0];
                    y_q      <= pix_y[6:0];
                    colour_q <= BG_COLOUR;
                    plot_q   <= pix_in;
                    if (dx_last) begin
                        dx_q <= 3'd0;
                        dy_q <= dy_q + 3'd1;
                    end else begin
                        dx_q <= dx_q + 3'd1;
                    end
                    if (dx_last && dy_last) begin
                        dx_q <= 3'd0;
                        dy_q <= 3'd0;
                        if (snap_size_q != 3'd0) begin
                            state_q <= S_DRAW;
                        end else begin
                            shadow_valid_q[snap_id_q] <= 1'b0;
                            state_q                   <= S_IDLE;
                        end
                    end
                end
                S_DRAW: begin
                    x_q      <= pix_x[7:0];
                    y_q      <= pix_y[6:0];
                    colour_q <= snap_colour_q;
                    plot_q   <= pix_in;
                    if (dx_last) begin
                        dx_q <= 3'd0;
                        dy_q <= dy_q + 3'd1;
                    end else begin
                        dx_q <= dx_q + 3'd1;
                    end
                    if (dx_last && dy_last) begin
                        dx_q                      <= 3'd0;
                        dy_q                      <= 3'd0;
                        shadow_x_q[snap_id_q]     <= snap_x_q;
                        shadow_y_q[snap_id_q]     <= snap_y_q;
                        shadow_size_q[snap_id_q]  <= snap_size_q;
                        shadow_valid_q[snap_id_q] <= 1'b1;
                        state_q                   <= S_IDLE;
                    end
                end
`ifdef SPRITE_RENDERER_CLEAR_EN
                S_CLEAR: begin
                    x_q      <= cx_q;
                    y_q      <= cy_q;
                    colour_q <= BG_COLOUR;
                    plot_q   <= 1'b1;
                    if (cx_q == 8'd159) begin
                        cx_q <= 8'd0;
                        if (cy_q == 7'd119) begin
                            cy_q    <= 7'd0;
                            state_q <= S_IDLE;
                        end else begin
                            cy_q <= cy_q + 7'd1;
                        end
                    end else begin
                        cx_q <= cx_q + 8'd1;
                    end
                end
`endif
                default: begin
                    plot_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: stimulus pushes expected pixels into a
// queue from a footprint-level model; a monitor pops and compares on every plot.
module tb_sprite_renderer;
    localparam logic [2:0] PLAYER_COLOUR = 3'b010;
    localparam logic [2:0] BULLET_COLOUR = 3'b110;
    localparam logic [2:0] BG_COLOUR     = 3'b000;
    localparam int         PLAYER_W      = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       load_level = 1'b0;
    logic       player_move = 1'b0;
    logic [7:0] playerX = 8'd0;
    logic [6:0] playerY = 7'd0;
    logic       enemy_move = 1'b0;
    logic [7:0] enemyX = 8'd0;
    logic [6:0] enemyY = 7'd0;
    logic [2:0] enemy_width = 3'd0;
    logic [2:0] enemy_color = 3'd0;
    logic       bullet_move = 1'b0;
    logic [7:0] bulletX = 8'd0;
    logic [6:0] bulletY = 7'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    always #5 clk = ~clk;

    sprite_renderer dut (
        .clk(clk), .resetn(resetn), .load_level(load_level),
        .player_move(player_move), .playerX(playerX), .playerY(playerY),
        .enemy_move(enemy_move), .enemyX(enemyX), .enemyY(enemyY),
        .enemy_width(enemy_width), .enemy_color(enemy_color),
        .bullet_move(bullet_move), .bulletX(bulletX), .bulletY(bulletY),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int plot_count = 0;
    logic [17:0] exp_q[$];

    // Reference: what each sprite currently has on screen
    int sh_x[3];
    int sh_y[3];
    int sh_w[3];
    bit sh_v[3];

    function automatic void push_px(int px, int py, logic [2:0] c);
        if (px < 160 && py < 120) exp_q.push_back({8'(px), 7'(py), c});
    endfunction

    // One service of sprite id: erase what is on screen, draw the new square
    function automatic void model_service(int id, int nx, int ny, int nw, logic [2:0] c);
        if (sh_v[id])
            for (int dy = 0; dy < sh_w[id]; dy++)
                for (int dx = 0; dx < sh_w[id]; dx++)
                    push_px(sh_x[id] + dx, sh_y[id] + dy, BG_COLOUR);
        for (int dy = 0; dy < nw; dy++)
            for (int dx = 0; dx < nw; dx++)
                push_px(nx + dx, ny + dy, c);
        sh_v[id] = (nw != 0);
        sh_x[id] = nx;
        sh_y[id] = ny;
        sh_w[id] = nw;
    endfunction

    function automatic void model_forget();
        for (int i = 0; i < 3; i++) sh_v[i] = 1'b0;
    endfunction

    // Monitor: every plotted pixel must be the next expected one
    always @(negedge clk) begin
        if (resetn && plot) begin
            plot_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: got unexpected plot x=%0d y=%0d colour=%0d, required no plot",
                         x, y, colour);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({x, y, colour} !== e) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             x, y, colour, e[17:10], e[9:3], e[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Issue a batch of simultaneous move pulses; coordinates stay held afterwards
    task automatic move_batch(input bit pm, input bit em, input bit bm,
                              input int px, input int py,
                              input int ex, input int ey, input int ew, input int ec,
                              input int bx, input int by);
        @(negedge clk);
        playerX = 8'(px); playerY = 7'(py);
        enemyX = 8'(ex); enemyY = 7'(ey); enemy_width = 3'(ew); enemy_color = 3'(ec);
        bulletX = 8'(bx); bulletY = 7'(by);
        player_move = pm; enemy_move = em; bullet_move = bm;
        if (pm) model_service(0, px, py, PLAYER_W, PLAYER_COLOUR);
        if (em) model_service(1, ex, ey, ew, 3'(ec));
        if (bm) model_service(2, bx, by, 1, BULLET_COLOUR);
        $display("txn pm=%0d em=%0d bm=%0d player=(%0d,%0d) enemy=(%0d,%0d) w=%0d c=%0d bullet=(%0d,%0d) expect_px=%0d",
                 pm, em, bm, px, py, ex, ey, ew, ec, bx, by, exp_q.size());
        @(negedge clk);
        player_move = 1'b0; enemy_move = 1'b0; bullet_move = 1'b0;
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_level = 1'b1;
`ifdef SPRITE_RENDERER_CLEAR_EN
        for (int cy = 0; cy < 120; cy++)
            for (int cx = 0; cx < 160; cx++)
                push_px(cx, cy, BG_COLOUR);
`endif
        model_forget();
        $display("txn load_level expect_px=%0d", exp_q.size());
        @(negedge clk);
        load_level = 1'b0;
    endtask

    // Wait for the DUT to settle idle with every expected pixel delivered
    task automatic wait_idle(input int limit);
        int stable = 0;
        int n = 0;
        while (stable < 3 && n < limit) begin
            @(negedge clk);
            n++;
            if (!busy && !plot && exp_q.size() == 0) stable++;
            else stable = 0;
        end
        checks++;
        if (stable < 3) begin
            errors++;
            $display("FAIL idle: got busy=%0d outstanding=%0d after %0d cycles, required busy=0 outstanding=0",
                     busy, exp_q.size(), n);
        end
    endtask

    function automatic int rand_x();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
    endfunction

    function automatic int rand_y();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
    endfunction

    initial begin
        int in_cnt;
        int oob_cnt;
        int base;
        bit hit;
        model_forget();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_x", x, 0);
        check("reset_y", y, 0);
        check("reset_colour", colour, 0);
        check("reset_plot", plot, 0);
        check("reset_busy", busy, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // First draw and its latency: plot appears two edges after the sampling edge
        move_batch(1, 0, 0, 80, 115, 0, 0, 0, 0, 0, 0);
        check("latency_sample_edge", plot, 0);
        @(negedge clk);
        check("latency_plus1", plot, 0);
        @(negedge clk);
        check("latency_plus2", plot, 1);
        wait_idle(200);
        check("busy_after_draw", busy, 0);

        // Move left one: erase then redraw
        move_batch(1, 0, 0, 79, 115, 0, 0, 0, 0, 0, 0);
        wait_idle(200);

        // Simultaneous player and bullet: player first
        move_batch(1, 0, 1, 80, 115, 0, 0, 0, 0, 81, 115);
        wait_idle(200);

        // Enemy straddling the right edge: 16 scan cycles, 8 visible
        move_batch(0, 1, 0, 80, 115, 158, 10, 4, 5, 81, 115);
        @(negedge clk);
        in_cnt = 0;
        oob_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (plot && x < 8'd160) in_cnt++;
            if (!plot && x >= 8'd160) oob_cnt++;
        end
        check("enemy_visible_plots", in_cnt, 8);
        check("enemy_offscreen_cycles", oob_cnt, 8);
        wait_idle(200);

        // Same sprite moved again while being serviced: serviced twice
        move_batch(1, 0, 0, 30, 40, 158, 10, 4, 5, 81, 115);
        @(negedge clk);
        @(negedge clk);
        move_batch(1, 0, 0, 33, 41, 158, 10, 4, 5, 81, 115);
        wait_idle(300);

        // Randomised batches
        for (int t = 0; t < 60; t++) begin
            bit pm, em, bm;
`ifndef SPRITE_RENDERER_CLEAR_EN
            if ($urandom_range(0, 9) == 0) begin
                pulse_load();
                wait_idle(50);
                continue;
            end
`endif
            pm = 1'($urandom_range(0, 1));
            em = 1'($urandom_range(0, 1));
            bm = 1'($urandom_range(0, 1));
            if (!pm && !em && !bm) pm = 1'b1;
            move_batch(pm, em, bm, rand_x(), rand_y(), rand_x(), rand_y(),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rand_x(), rand_y());
            wait_idle(400);
        end

        // Reset during the 5th pixel of a fresh draw aborts everything
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        model_forget();
        move_batch(1, 0, 0, 50, 60, 0, 0, 0, 0, 0, 0);
        base = plot_count;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (plot_count == base + 5) hit = 1'b1;
        end
        check("reached_fifth_pixel", int'(hit), 1);
        resetn = 1'b0;
        #1;
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_x", x, 0);
        check("abort_y", y, 0);
        check("abort_colour", colour, 0);
        exp_q.delete();
        model_forget();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        move_batch(1, 0, 0, 52, 61, 0, 0, 0, 0, 0, 0);
        wait_idle(200);

`ifdef SPRITE_RENDERER_CLEAR_EN
        // Full clear with a player move arriving mid-clear
        pulse_load();
        repeat (100) @(negedge clk);
        check("busy_during_clear", busy, 1);
        move_batch(1, 0, 0, 10, 20, 0, 0, 0, 0, 0, 0);
        wait_idle(25000);
        check("busy_after_clear", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Downstream consumer of player_control, enemy_control and bullet_control.
- Turns their move pulses and coordinates into a serial pixel stream for the 160x120, 3-bit-colour VGA adapter (x, y, colour, plot).
- For each moved sprite, erases the previously drawn footprint with background colour, then draws the new footprint. One pixel per clock.

Parameters:
- PLAYER_W, 3, player square size in pixels
- PLAYER_COLOUR, 3'b010, player colour
- BULLET_COLOUR, 3'b110, bullet colour (bullet is 1x1)
- BG_COLOUR, 3'b000, erase/clear colour

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- load_level  in  1  level-load pulse (same signal fed to the control blocks)
- player_move  in  1  one-cycle pulse: player position changed
- playerX  in  8  player top-left x
- playerY  in  7  player top-left y
- enemy_move  in  1  one-cycle pulse: enemy position changed
- enemyX  in  8  enemy top-left x
- enemyY  in  7  enemy top-left y
- enemy_width  in  3  enemy square size; 0 = no enemy
- enemy_color  in  3  enemy colour
- bullet_move  in  1  one-cycle pulse: bullet position changed
- bulletX  in  8  bullet x
- bulletY  in  7  bullet y
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  write strobe to VGA adapter
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, resetn=0):
  - x=0, y=0, colour=0, plot=0, busy=0.
  - All pending flags cleared; all shadow-valid bits cleared; FSM to IDLE.
  - Reset mid-operation aborts immediately. No partial completion.
- Pending flags (player, enemy, bullet):
  - Set on the clk edge sampling the corresponding move pulse, in any state.
  - Cleared when the FSM accepts that sprite.
  - A pulse arriving during service of the same sprite re-sets its flag. It is serviced again later.
- Shadow registers per sprite: last drawn x, y, size, valid.
- FSM states IDLE, ERASE, DRAW.
- IDLE:
  - If any flag is set, select by fixed priority: player > enemy > bullet.
  - Snapshot the sprite's current inputs (coords, size, colour) and clear its flag.
  - Go to ERASE if shadow valid, else DRAW.
  - busy=0 only here.
- ERASE:
  - Scan the shadow footprint row-major: dx fastest, then dy, each from 0 to size-1.
  - Emit one pixel per cycle with colour=BG_COLOUR.
  - After the last pixel, go to DRAW.
- DRAW:
  - Scan the snapshot footprint the same way.
  - Colour: PLAYER_COLOUR, snapshot enemy_color, or BULLET_COLOUR.
  - After the last pixel: shadow <= snapshot, valid=1, go to IDLE.
- Size 0 (enemy_width=0): the DRAW scan emits nothing and shadow valid is set to 0. ERASE of a size-0 shadow is likewise empty.
- Outputs are registered:
  - First plot is asserted 2 cycles after the edge that samples the move pulse when the FSM is idle.
  - Service time is old_size^2 + new_size^2 cycles, plus 1 IDLE cycle between services.
- Arithmetic:
  - Coordinate + offset is computed in 9/8 bits.
  - A pixel with x>=160 or y>=120 still consumes its cycle but drives plot=0.
- load_level:
  - Clears all shadow-valid bits and pending flags, on the edge where it is sampled, in any state. An active scan is aborted and the FSM goes to IDLE (macro off).

Optional Feature:
- Macro: SPRITE_RENDERER_CLEAR_EN.
- Defined:
  - load_level additionally enters state CLEAR.
  - CLEAR scans all 160x120 pixels row-major from (0,0) to (159,119) with colour=BG_COLOUR and plot=1: 19200 cycles, busy=1.
  - Move pulses during CLEAR set pending flags normally and are serviced after CLEAR returns to IDLE.
- Undefined: no CLEAR state; load_level behaves as described in Behaviour.

Test Plan:
- Reset, then player_move with (80,115):
  - 9 plots, colour 3'b010, order (80,115),(81,115),(82,115),(80,116)…(82,117).
  - No erase; first plot 2 cycles after the pulse; busy low after.
- Then player_move with (79,115):
  - 9 plots colour 0 at x 80..82, y 115..117.
  - Then 9 plots colour 3'b010 at x 79..81.
- player_move and bullet_move in the same cycle (player (80,115), bullet (81,115)):
  - Player serviced first (9 plots), then one plot (81,115) colour 3'b110.
- enemy_move with (158,10), width 4, colour 3'b101:
  - 16 scan cycles; plot=1 only for x in 158..159 (8 pixels).
  - plot=0 on the 8 cycles with x=160,161.
- Assert resetn=0 during the 5th DRAW pixel:
  - plot, busy, x, y, colour are 0 in the same cycle.
  - A subsequent player_move draws with no erase.
- With SPRITE_RENDERER_CLEAR_EN, pulse load_level:
  - Exactly 19200 plots of colour 0, ending at (159,119), then busy=0.
  - A player_move issued mid-clear is drawn afterwards.
